// File: rtl/reg_write_scoreboard.sv
// Write-side register scoreboard: counts in-flight writes per register and
// stalls issue while any source or a full destination counter is busy.
module reg_write_scoreboard #(
    parameter int INDEX_BIT_WIDTH = 4,
    parameter int N_REGS          = 1 << INDEX_BIT_WIDTH,
    parameter int CNT_WIDTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issueValid,
    input  logic                       issueWrtEn,
    input  logic [INDEX_BIT_WIDTH-1:0] issueWrtIndex,
    input  logic                       issueRdUse1,
    input  logic [INDEX_BIT_WIDTH-1:0] issueRdIndex1,
    input  logic                       issueRdUse2,
    input  logic [INDEX_BIT_WIDTH-1:0] issueRdIndex2,
    input  logic                       wbWrtEn,
    input  logic [INDEX_BIT_WIDTH-1:0] wbWrtIndex,
    input  logic                       flush,
    output logic                       stall,
    output logic [N_REGS-1:0]          pendingMask,
    output logic                       underflowErr
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [N_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [N_REGS];
    logic                 err_q;
    logic                 err_d;

    logic hazard1;
    logic hazard2;
    logic dest_full;
    logic issue_inc;
    logic wb_dec;
    logic wb_underflow;

    // Hazards look at registered counters only: a retire this cycle is not
    // visible to a read this cycle because the register file has no bypass.
    assign hazard1   = issueRdUse1 && (cnt_q[issueRdIndex1] != '0);
    assign hazard2   = issueRdUse2 && (cnt_q[issueRdIndex2] != '0);
    assign dest_full = issueWrtEn  && (cnt_q[issueWrtIndex] == CNT_MAX);
    assign stall     = issueValid && (hazard1 || hazard2 || dest_full);

    assign issue_inc    = issueValid && !stall && issueWrtEn;
    assign wb_dec       = wbWrtEn && (cnt_q[wbWrtIndex] != '0);
    assign wb_underflow = wbWrtEn && (cnt_q[wbWrtIndex] == '0);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        err_d = err_q;
        if (flush) begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            if (wb_underflow) begin
                err_d = 1'b1;
            end
            if (issue_inc && wb_dec && (issueWrtIndex == wbWrtIndex)) begin
                cnt_d[issueWrtIndex] = cnt_q[issueWrtIndex];
            end else begin
                if (issue_inc) begin
                    cnt_d[issueWrtIndex] = cnt_q[issueWrtIndex] + CNT_WIDTH'(1);
                end
                if (wb_dec) begin
                    cnt_d[wbWrtIndex] = cnt_q[wbWrtIndex] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // NOTE: the counter array is reset (not left uninitialised like a data
    // RAM) because its contents are control state that gates issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            pendingMask[i] = (cnt_q[i] != '0);
        end
    end

    assign underflowErr = err_q;

endmodule
